// File: rtl/troco_pkg.sv
// Shared types and coin constants for the change dispenser.
package troco_pkg;

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_e;
  typedef enum logic [1:0] {NONE, C25, C50, C100} coin_e;

  localparam int unsigned UNIT_25 = 1;
  localparam int unsigned UNIT_50 = 2;
  localparam int unsigned UNIT_1  = 4;

  function automatic int unsigned coin_units(input coin_e c);
    case (c)
      C25:     return UNIT_25;
      C50:     return UNIT_50;
      C100:    return UNIT_1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/dispensa_troco_contador_pulso.sv
// Loadable down-counter that holds at zero; times eject pulses and gaps.
module contador_pulso #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)              r_cnt <= '0;
    else if (i_load)        r_cnt <= i_load_val;
    else if (r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dispensa_troco.sv
// Greedy change dispenser: pays an amount in 25c units as timed solenoid
// pulses (R$1, 50c, 25c), tracking per-coin stock and flagging shortages.
module dispensa_troco
  import troco_pkg::*;
#(
  parameter int unsigned AMT_W        = 4,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned STOCK_INIT   = 8,
  parameter int unsigned PULSE_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 50000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_troco_valid,
  input  logic [AMT_W-1:0] i_troco_units,
  output logic             o_ready,
  input  logic             i_refill,
  output logic             o_eject_1,
  output logic             o_eject_50,
  output logic             o_eject_25,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_falta,
  output logic [AMT_W-1:0] o_restante
);

  localparam int unsigned MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = $clog2(MAXC + 1);
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

  state_e             r_state, w_next;
  coin_e              r_coin, w_pick;
  logic [AMT_W-1:0]   r_rem;
  logic [STOCK_W-1:0] r_stock_1, r_stock_50, r_stock_25;
  logic               w_launch, w_load, w_zero;
  logic [TW-1:0]      w_load_val;

  contador_pulso #(.W(TW)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  always_comb begin
    w_pick = NONE;
    if (r_rem >= AMT_W'(UNIT_1) && r_stock_1 != '0)        w_pick = C100;
    else if (r_rem >= AMT_W'(UNIT_50) && r_stock_50 != '0) w_pick = C50;
    else if (r_rem != '0 && r_stock_25 != '0)             w_pick = C25;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // At the end of a gap the next coin launches straight into PULSE; SELECT is
  // only revisited to finish (DONE) or to abort on shortage.
  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_load     = 1'b0;
    w_load_val = PULSE_LD;
    unique case (r_state)
      IDLE:   if (i_troco_valid) w_next = (i_troco_units == '0) ? DONE : SELECT;
      SELECT: begin
        if (w_pick != NONE) begin
          w_next   = PULSE;
          w_launch = 1'b1;
          w_load   = 1'b1;
        end else if (r_rem == '0) begin
          w_next = DONE;
        end else begin
          w_next = IDLE;
        end
      end
      PULSE:  if (w_zero) begin
        w_next     = GAP;
        w_load     = 1'b1;
        w_load_val = GAP_LD;
      end
      GAP:    if (w_zero) begin
        if (w_pick != NONE) begin
          w_next   = PULSE;
          w_launch = 1'b1;
          w_load   = 1'b1;
        end else begin
          w_next = SELECT;
        end
      end
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rem      <= '0;
      r_coin     <= NONE;
      r_stock_1  <= STOCK_W'(STOCK_INIT);
      r_stock_50 <= STOCK_W'(STOCK_INIT);
      r_stock_25 <= STOCK_W'(STOCK_INIT);
    end else begin
      if (r_state == IDLE && i_troco_valid) r_rem <= i_troco_units;
      if (r_state == IDLE && i_refill) begin
        r_stock_1  <= '1;
        r_stock_50 <= '1;
        r_stock_25 <= '1;
      end
      if (w_launch) begin
        r_coin <= w_pick;
        r_rem  <= r_rem - AMT_W'(coin_units(w_pick));
        if (w_pick == C100) r_stock_1  <= r_stock_1  - STOCK_W'(1);
        if (w_pick == C50)  r_stock_50 <= r_stock_50 - STOCK_W'(1);
        if (w_pick == C25)  r_stock_25 <= r_stock_25 - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    o_ready    = (r_state == IDLE);
    o_busy     = (r_state == SELECT) || (r_state == PULSE) || (r_state == GAP);
    o_eject_1  = (r_state == PULSE) && (r_coin == C100);
    o_eject_50 = (r_state == PULSE) && (r_coin == C50);
    o_eject_25 = (r_state == PULSE) && (r_coin == C25);
    o_done     = (r_state == DONE);
    o_falta    = (r_state == SELECT) && (w_pick == NONE) && (r_rem != '0);
    o_restante = r_rem;
  end

endmodule

// File: tb/tb_dispensa_troco.sv
// Randomised self-checking bench for dispensa_troco against a greedy-change model.
module tb_dispensa_troco;

  localparam int unsigned P = 3;
  localparam int unsigned G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       valid = 1'b0;
  logic       refill = 1'b0;
  logic [3:0] units = '0;

  logic       a_rdy, a_e1, a_e50, a_e25, a_busy, a_done, a_falta;
  logic       b_rdy, b_e1, b_e50, b_e25, b_busy, b_done, b_falta;
  logic [3:0] a_rest, b_rest;
  logic       ob_rdy, ob_e1, ob_e50, ob_e25, ob_busy, ob_done, ob_falta;
  logic [3:0] ob_rest;

  int checks = 0;
  int failures = 0;
  int unsigned m_stock [2][3];

  always #5 clk = ~clk;

  dispensa_troco #(.AMT_W(4), .STOCK_W(4), .STOCK_INIT(8), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_troco_valid(valid & ~sel), .i_troco_units(units),
    .o_ready(a_rdy), .i_refill(refill & ~sel), .o_eject_1(a_e1), .o_eject_50(a_e50),
    .o_eject_25(a_e25), .o_busy(a_busy), .o_done(a_done), .o_falta(a_falta), .o_restante(a_rest));

  dispensa_troco #(.AMT_W(4), .STOCK_W(4), .STOCK_INIT(1), .PULSE_CYCLES(P), .GAP_CYCLES(G)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_troco_valid(valid & sel), .i_troco_units(units),
    .o_ready(b_rdy), .i_refill(refill & sel), .o_eject_1(b_e1), .o_eject_50(b_e50),
    .o_eject_25(b_e25), .o_busy(b_busy), .o_done(b_done), .o_falta(b_falta), .o_restante(b_rest));

  always_comb begin
    ob_rdy   = sel ? b_rdy   : a_rdy;
    ob_e1    = sel ? b_e1    : a_e1;
    ob_e50   = sel ? b_e50   : a_e50;
    ob_e25   = sel ? b_e25   : a_e25;
    ob_busy  = sel ? b_busy  : a_busy;
    ob_done  = sel ? b_done  : a_done;
    ob_falta = sel ? b_falta : a_falta;
    ob_rest  = sel ? b_rest  : a_rest;
  end

  function automatic logic [11:0] dut_stocks();
    if (sel) return {dut_b.r_stock_1, dut_b.r_stock_50, dut_b.r_stock_25};
    return {dut_a.r_stock_1, dut_a.r_stock_50, dut_a.r_stock_25};
  endfunction

  function automatic logic [11:0] model_stocks();
    int unsigned s = sel ? 1 : 0;
    return {4'(m_stock[s][0]), 4'(m_stock[s][1]), 4'(m_stock[s][2])};
  endfunction

  task automatic reset_model();
    for (int j = 0; j < 3; j++) begin
      m_stock[0][j] = 8;
      m_stock[1][j] = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reset_model();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      checks++;
      if ({ob_rdy, ob_busy, ob_e1, ob_e50, ob_e25, ob_done, ob_falta, ob_rest} !== 11'b10_00000_0000) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got=%b want=%b", i,
                 {ob_rdy, ob_busy, ob_e1, ob_e50, ob_e25, ob_done, ob_falta, ob_rest}, 11'b10_00000_0000);
      end
      checks++;
      if (dut_stocks() !== model_stocks()) begin
        failures++;
        $display("FAIL reset_stocks inst=%0d got=%h want=%h", i, dut_stocks(), model_stocks());
      end
    end
    sel = 1'b0;
    rst = 1'b0;
  endtask

  // mode: 0 plain, 1 competing request during payout, 2 refill during first gap
  task automatic run_payout(input int unsigned amt, input int unsigned mode,
                            input bit with_refill, input string nm);
    int unsigned exp_u[$];
    int unsigned obs_u[$];
    int unsigned obs_start[$];
    int unsigned obs_len[$];
    int unsigned s, r, k, exp_end, n_done, n_falta, done_c, falta_c;
    bit fault, multi;
    logic [2:0] ej, prev;

    s = sel ? 1 : 0;
    if (with_refill) for (int j = 0; j < 3; j++) m_stock[s][j] = 15;
    r = amt;
    fault = 1'b0;
    while (r != 0 && !fault) begin
      if (r >= 4 && m_stock[s][0] > 0)      begin exp_u.push_back(4); m_stock[s][0]--; r -= 4; end
      else if (r >= 2 && m_stock[s][1] > 0) begin exp_u.push_back(2); m_stock[s][1]--; r -= 2; end
      else if (m_stock[s][2] > 0)           begin exp_u.push_back(1); m_stock[s][2]--; r -= 1; end
      else fault = 1'b1;
    end
    k = exp_u.size();
    exp_end = (k == 0) ? 1 : 2 + k * (P + G) + (fault ? 0 : 1);

    @(negedge clk);
    valid = 1'b1;
    units = 4'(amt);
    refill = with_refill;
    n_done = 0; n_falta = 0; done_c = 0; falta_c = 0;
    multi = 1'b0;
    prev = 3'b000;
    for (int unsigned c = 1; c <= exp_end + 1; c++) begin
      @(negedge clk);
      ej = {ob_e1, ob_e50, ob_e25};
      if ((ej & (ej - 3'd1)) != 3'd0) multi = 1'b1;
      if (ej != 3'b000) begin
        if (ej != prev) begin
          obs_u.push_back(ej == 3'b100 ? 4 : ej == 3'b010 ? 2 : ej == 3'b001 ? 1 : 99);
          obs_start.push_back(c);
          obs_len.push_back(1);
        end else begin
          obs_len[obs_len.size()-1]++;
        end
      end
      prev = ej;
      if (ob_done)  begin n_done++;  done_c = c;  end
      if (ob_falta) begin n_falta++; falta_c = c; end
      if (c == 1) begin valid = 1'b0; refill = 1'b0; end
      if (c == 3 && k > 0) begin
        checks++;
        if (ob_busy !== 1'b1 || ob_rdy !== 1'b0) begin
          failures++;
          $display("FAIL %s busy_mid got busy=%b ready=%b want busy=1 ready=0", nm, ob_busy, ob_rdy);
        end
        if (mode == 1) begin valid = 1'b1; units = 4'(amt ^ 5); end
      end
      if (c == 6 && mode == 1) valid = 1'b0;
      if (c == 5 && mode == 2) refill = 1'b1;
      if (c == 6 && mode == 2) refill = 1'b0;
    end
    valid = 1'b0;
    refill = 1'b0;

    checks++;
    if (obs_u.size() != k) begin
      failures++;
      $display("FAIL %s coin_count got=%0d want=%0d", nm, obs_u.size(), k);
    end
    for (int i = 0; i < obs_u.size() && i < k; i++) begin
      checks++;
      if (obs_u[i] != exp_u[i] || obs_start[i] != 2 + i * (P + G) || obs_len[i] != P) begin
        failures++;
        $display("FAIL %s coin%0d got units=%0d start=%0d len=%0d want units=%0d start=%0d len=%0d",
                 nm, i, obs_u[i], obs_start[i], obs_len[i], exp_u[i], 2 + i * (P + G), P);
      end
    end
    checks++;
    if (multi) begin
      failures++;
      $display("FAIL %s one_hot got multiple ejects high want at most one", nm);
    end
    checks++;
    if (fault) begin
      if (n_falta != 1 || falta_c != exp_end || n_done != 0) begin
        failures++;
        $display("FAIL %s falta got n_falta=%0d at=%0d n_done=%0d want 1 at=%0d n_done=0",
                 nm, n_falta, falta_c, n_done, exp_end);
      end
    end else begin
      if (n_done != 1 || done_c != exp_end || n_falta != 0) begin
        failures++;
        $display("FAIL %s done got n_done=%0d at=%0d n_falta=%0d want 1 at=%0d n_falta=0",
                 nm, n_done, done_c, n_falta, exp_end);
      end
    end
    checks++;
    if (ob_rdy !== 1'b1 || ob_rest !== 4'(r)) begin
      failures++;
      $display("FAIL %s end_state got ready=%b restante=%0d want ready=1 restante=%0d", nm, ob_rdy, ob_rest, r);
    end
    checks++;
    if (dut_stocks() !== model_stocks()) begin
      failures++;
      $display("FAIL %s stocks got=%h want=%h", nm, dut_stocks(), model_stocks());
    end
    for (int w = 0; w < 200 && ob_rdy !== 1'b1; w++) @(negedge clk);
    checks++;
    if (ob_rdy !== 1'b1) begin
      failures++;
      $display("FAIL %s resync got ready=%b want 1", nm, ob_rdy);
    end
  endtask

  task automatic test_exact_change();
    sel = 1'b0;
    run_payout(7, 0, 1'b0, "pay7");
    run_payout(0, 0, 1'b0, "pay0");
  endtask

  task automatic test_ignore_valid();
    sel = 1'b0;
    run_payout(6, 1, 1'b0, "ignore_valid");
  endtask

  task automatic test_refill_in_gap();
    sel = 1'b0;
    run_payout(7, 2, 1'b0, "refill_gap");
  endtask

  task automatic test_shortage();
    sel = 1'b1;
    run_payout(4, 0, 1'b0, "short_r1");
    run_payout(4, 0, 1'b0, "short_falta");
    run_payout(1, 0, 1'b1, "short_refill");
    sel = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      sel = ($urandom_range(0, 2) == 0);
      run_payout($urandom_range(0, 15), 0, ($urandom_range(0, 3) == 0), "random");
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    units = 4'd7;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ob_e1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre got eject_1=%b want 1", ob_e1);
    end
    rst = 1'b1;
    reset_model();
    @(negedge clk);
    checks++;
    if ({ob_e1, ob_e50, ob_e25, ob_done, ob_falta, ob_rdy} !== 6'b000001) begin
      failures++;
      $display("FAIL reset_mid_out got=%b want=000001", {ob_e1, ob_e50, ob_e25, ob_done, ob_falta, ob_rdy});
    end
    checks++;
    if (dut_stocks() !== model_stocks()) begin
      failures++;
      $display("FAIL reset_mid_stocks got=%h want=%h", dut_stocks(), model_stocks());
    end
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ob_e1 || ob_e50 || ob_e25 || ob_done || ob_falta || !ob_rdy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_mid_quiet got activity after reset want idle");
    end
  endtask

  initial begin
    test_reset();
    test_exact_change();
    test_ignore_valid();
    test_refill_in_gap();
    test_shortage();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
